// File: rtl/fbp_axil_regs.sv
// AXI4-Lite register file for the FBP accelerator: config, status, and two base-address words.
// Optional macro FBP_REGS_SLVERR_EN: writes to the read-only status offset answer SLVERR instead of OKAY.
module fbp_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH         = 32,
  parameter int          C_S_AXI_ADDR_WIDTH         = 4,
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h60000000
) (
  input  logic                              clk,
  input  logic                              arstn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [3:0]                        slv_reg_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     config_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     status_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     angle_data_base_addr_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     img_base_addr_reg3,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1_update
);

  logic        aw_full;
  logic [1:0]  aw_addr_q;
  logic        w_full;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        commit;
  logic        unused_ok;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = arstn & ~aw_full & ~s_axi_bvalid;
  assign s_axi_wready  = arstn & ~w_full & ~s_axi_bvalid;
  assign s_axi_arready = arstn & ~s_axi_rvalid;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = aw_full & w_full & ~s_axi_bvalid;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  // Write path: AW and W land in independent holding slots; the commit fires once both are full.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      aw_full                   <= 1'b0;
      aw_addr_q                 <= '0;
      w_full                    <= 1'b0;
      w_data_q                  <= '0;
      w_strb_q                  <= '0;
      s_axi_bvalid              <= 1'b0;
      s_axi_bresp               <= '0;
      slv_reg_valid             <= '0;
      config_reg0               <= '0;
      status_reg1               <= '0;
      angle_data_base_addr_reg2 <= C_M_TARGET_SLAVE_BASE_ADDR;
      img_base_addr_reg3        <= C_M_TARGET_SLAVE_BASE_ADDR;
    end else begin
      slv_reg_valid <= '0;
      status_reg1   <= slv_reg1_update;
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi_bvalid <= 1'b1;
`ifdef FBP_REGS_SLVERR_EN
        s_axi_bresp  <= (aw_addr_q == 2'd1) ? 2'b10 : 2'b00;
`else
        s_axi_bresp  <= 2'b00;
`endif
        case (aw_addr_q)
          2'd0: begin
            config_reg0   <= merge_strb(config_reg0, w_data_q, w_strb_q);
            slv_reg_valid <= 4'b0001;
          end
          2'd2: begin
            angle_data_base_addr_reg2 <= merge_strb(angle_data_base_addr_reg2, w_data_q, w_strb_q);
            slv_reg_valid             <= 4'b0100;
          end
          2'd3: begin
            img_base_addr_reg3 <= merge_strb(img_base_addr_reg3, w_data_q, w_strb_q);
            slv_reg_valid      <= 4'b1000;
          end
          default: ;
        endcase
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read path samples pre-edge register values, so a same-edge commit is not visible.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rresp  <= 2'b00;
      case (s_axi_araddr[3:2])
        2'd0:    s_axi_rdata <= config_reg0;
        2'd1:    s_axi_rdata <= status_reg1;
        2'd2:    s_axi_rdata <= angle_data_base_addr_reg2;
        default: s_axi_rdata <= img_base_addr_reg3;
      endcase
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fbp_axil_regs.sv
// Directed-vector bench for fbp_axil_regs; expected values are hand-computed constants.
module tb_fbp_axil_regs;

  logic        clk;
  logic        arstn;
  logic [3:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [3:0]  slv_reg_valid;
  logic [31:0] config_reg0;
  logic [31:0] status_reg1;
  logic [31:0] angle_data_base_addr_reg2;
  logic [31:0] img_base_addr_reg3;
  logic [31:0] slv_reg1_update;

  int vectors = 0;
  int miscompares = 0;

`ifdef FBP_REGS_SLVERR_EN
  localparam logic [1:0] EXP_RO_BRESP = 2'b10;
`else
  localparam logic [1:0] EXP_RO_BRESP = 2'b00;
`endif

  fbp_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_M_TARGET_SLAVE_BASE_ADDR(32'h60000000)
  ) dut (
    .clk(clk),
    .arstn(arstn),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .slv_reg_valid(slv_reg_valid),
    .config_reg0(config_reg0),
    .status_reg1(status_reg1),
    .angle_data_base_addr_reg2(angle_data_base_addr_reg2),
    .img_base_addr_reg3(img_base_addr_reg3),
    .slv_reg1_update(slv_reg1_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    while (!s_axi_arready && n < 20) begin
      step();
      n++;
    end
    check_val("ar_wait", 32'(n < 20), 32'd1);
    step();
    s_axi_arvalid = 1'b0;
    check_val("rd_rvalid", 32'(s_axi_rvalid), 32'd1);
    d = s_axi_rdata;
    r = s_axi_rresp;
    s_axi_rready = 1'b1;
    step();
    s_axi_rready = 1'b0;
  endtask

  task automatic send_aw_w(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    check_val("aw_w_ready", {30'd0, s_axi_awready, s_axi_wready}, 32'd3);
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_wvalid  = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    arstn = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    slv_reg1_update = 32'hCAFE0001;
    repeat (3) step();

    check_val("rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    check_val("rst_valids", {28'd0, s_axi_bvalid, s_axi_rvalid, s_axi_bresp}, 32'd0);
    check_val("rst_strobe", 32'(slv_reg_valid), 32'd0);
    check_val("rst_reg0", config_reg0, 32'h0);
    check_val("rst_reg1", status_reg1, 32'h0);
    check_val("rst_reg2", angle_data_base_addr_reg2, 32'h60000000);
    check_val("rst_reg3", img_base_addr_reg3, 32'h60000000);
    check_val("rst_rdata", s_axi_rdata, 32'h0);

    arstn = 1'b1;
    step();
    do_read(4'h0, rd, rr); check_val("rd0", rd, 32'h0);        check_val("rd0_resp", 32'(rr), 32'd0);
    do_read(4'h4, rd, rr); check_val("rd1", rd, 32'hCAFE0001); check_val("rd1_resp", 32'(rr), 32'd0);
    do_read(4'h8, rd, rr); check_val("rd2", rd, 32'h60000000); check_val("rd2_resp", 32'(rr), 32'd0);
    do_read(4'hD, rd, rr); check_val("rd3", rd, 32'h60000000); check_val("rd3_resp", 32'(rr), 32'd0);

    // Write 0x8 with AW and W together
    s_axi_bready = 1'b1;
    send_aw_w(4'h8, 32'h12345678, 4'hF);
    check_val("w8_pre_strobe", 32'(slv_reg_valid), 32'd0);
    check_val("w8_pre_bvalid", 32'(s_axi_bvalid), 32'd0);
    check_val("w8_pre_reg2", angle_data_base_addr_reg2, 32'h60000000);
    step();
    check_val("w8_reg2", angle_data_base_addr_reg2, 32'h12345678);
    check_val("w8_strobe", 32'(slv_reg_valid), 32'b0100);
    check_val("w8_bvalid", 32'(s_axi_bvalid), 32'd1);
    check_val("w8_bresp", 32'(s_axi_bresp), 32'd0);
    step();
    check_val("w8_strobe_end", 32'(slv_reg_valid), 32'd0);
    check_val("w8_bvalid_end", 32'(s_axi_bvalid), 32'd0);

    // W presented well ahead of AW, partial strobe
    check_val("wC_wready", 32'(s_axi_wready), 32'd1);
    s_axi_wdata = 32'hAAAABBBB; s_axi_wstrb = 4'b0011; s_axi_wvalid = 1'b1;
    step();
    s_axi_wvalid = 1'b0;
    repeat (5) begin
      check_val("wC_wready_held", 32'(s_axi_wready), 32'd0);
      check_val("wC_no_strobe", 32'(slv_reg_valid), 32'd0);
      step();
    end
    check_val("wC_awready", 32'(s_axi_awready), 32'd1);
    s_axi_awaddr = 4'hC; s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    check_val("wC_wready_pre", 32'(s_axi_wready), 32'd0);
    step();
    check_val("wC_reg3", img_base_addr_reg3, 32'h6000BBBB);
    check_val("wC_strobe", 32'(slv_reg_valid), 32'b1000);
    step();
    check_val("wC_strobe_end", 32'(slv_reg_valid), 32'd0);

    // Write 0x0 while B is back-pressured
    s_axi_bready = 1'b0;
    send_aw_w(4'h0, 32'h00000001, 4'hF);
    step();
    check_val("w0_reg0", config_reg0, 32'h1);
    check_val("w0_strobe", 32'(slv_reg_valid), 32'b0001);
    repeat (4) begin
      check_val("w0_bvalid_hold", 32'(s_axi_bvalid), 32'd1);
      check_val("w0_readies_low", {30'd0, s_axi_awready, s_axi_wready}, 32'd0);
      step();
      check_val("w0_no_strobe", 32'(slv_reg_valid), 32'd0);
    end
    s_axi_bready = 1'b1;
    step();
    check_val("w0_bvalid_done", 32'(s_axi_bvalid), 32'd0);
    check_val("w0_readies_back", {30'd0, s_axi_awready, s_axi_wready}, 32'd3);

    // Zero byte-strobe write still commits and pulses
    send_aw_w(4'h0, 32'hFFFFFFFF, 4'h0);
    step();
    check_val("ws0_reg0", config_reg0, 32'h1);
    check_val("ws0_strobe", 32'(slv_reg_valid), 32'b0001);
    check_val("ws0_bvalid", 32'(s_axi_bvalid), 32'd1);
    step();

    // Write to the read-only status offset
    slv_reg1_update = 32'h13579BDF;
    send_aw_w(4'h4, 32'hFFFFFFFF, 4'hF);
    step();
    check_val("w4_strobe", 32'(slv_reg_valid), 32'd0);
    check_val("w4_status", status_reg1, 32'h13579BDF);
    check_val("w4_bvalid", 32'(s_axi_bvalid), 32'd1);
    check_val("w4_bresp", 32'(s_axi_bresp), 32'(EXP_RO_BRESP));
    slv_reg1_update = 32'h2468ACE0;
    step();
    check_val("w4_status_track", status_reg1, 32'h2468ACE0);
    check_val("w4_others", config_reg0 ^ angle_data_base_addr_reg2 ^ img_base_addr_reg3,
              32'h1 ^ 32'h12345678 ^ 32'h6000BBBB);

    // Read of 0x8 on the same edge as a commit to 0x8, then reset during the R hold
    send_aw_w(4'h8, 32'hDEADBEEF, 4'hF);
    check_val("rw_arready", 32'(s_axi_arready), 32'd1);
    s_axi_araddr = 4'h8; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    step();
    s_axi_arvalid = 1'b0;
    check_val("rw_rvalid", 32'(s_axi_rvalid), 32'd1);
    check_val("rw_rdata_old", s_axi_rdata, 32'h12345678);
    check_val("rw_reg2_new", angle_data_base_addr_reg2, 32'hDEADBEEF);
    repeat (3) begin
      step();
      check_val("rw_rvalid_hold", 32'(s_axi_rvalid), 32'd1);
      check_val("rw_rdata_hold", s_axi_rdata, 32'h12345678);
    end
    arstn = 1'b0;
    step();
    check_val("rst2_rvalid", 32'(s_axi_rvalid), 32'd0);
    check_val("rst2_rdata", s_axi_rdata, 32'h0);
    check_val("rst2_reg0", config_reg0, 32'h0);
    check_val("rst2_reg2", angle_data_base_addr_reg2, 32'h60000000);
    check_val("rst2_reg3", img_base_addr_reg3, 32'h60000000);
    check_val("rst2_arready", 32'(s_axi_arready), 32'd0);
    arstn = 1'b1;
    step();
    check_val("rst2_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
